// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, mux selects, state codes.
// MC_CTRL_ADDI_EN adds the addi opcode to the legal set.
package mc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      OP_ADDI: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Output decode for the control FSM: (state, opcode, mem_ready) -> datapath strobes.
// MC_CTRL_ADDI_EN enables the ADDIEX/ADDIWB decodes; otherwise those codes decode to all-zero.
module mc_control_decode
  import mc_control_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = !op_legal(opcode);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_BRANCH;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ADDI_EN
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: state register and next-state logic; strobes come from mc_control_decode.
// MC_CTRL_ADDI_EN adds the ADDIEX/ADDIWB path for opcode 001000.
//
// state  | meaning
// FETCH  | read instruction, PC += 4 when memory ready
// DECODE | register read, branch target compute, dispatch on opcode
// MEMADR | lw/sw effective address
// MEMRD  | data read, waits on mem_ready
// MEMWB  | load result to rt
// MEMWR  | data write, waits on mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type result to rd
// BRANCH | beq compare, conditional PC write
// JUMP   | unconditional PC write
// ADDIEX | addi ALU operation (MC_CTRL_ADDI_EN)
// ADDIWB | addi result to rt (MC_CTRL_ADDI_EN)
module mc_control_fsm
  import mc_control_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  logic   mem_ok;

  // Masked by rst_n so FETCH issues no ir/pc write while reset is held.
  assign mem_ok = rst_n & ((MEM_HANDSHAKE != 0) ? mem_ready : 1'b1);
  assign state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  if (mem_ok) state_q <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_RTYPE:     state_q <= EXEC;
            OP_BEQ:       state_q <= BRANCH;
            OP_J:         state_q <= JUMP;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:      state_q <= ADDIEX;
`endif
            default:      state_q <= FETCH;
          endcase
        end
        // Opcode is re-read here; anything but lw/sw abandons the access.
        MEMADR: begin
          if (opcode == OP_LW)      state_q <= MEMRD;
          else if (opcode == OP_SW) state_q <= MEMWR;
          else                      state_q <= FETCH;
        end
        MEMRD:  if (mem_ok) state_q <= MEMWB;
        MEMWB:  state_q <= FETCH;
        MEMWR:  if (mem_ok) state_q <= FETCH;
        EXEC:   state_q <= ALUWB;
        ALUWB:  state_q <= FETCH;
        BRANCH: state_q <= FETCH;
        JUMP:   state_q <= FETCH;
`ifdef MC_CTRL_ADDI_EN
        ADDIEX: state_q <= ADDIWB;
        ADDIWB: state_q <= FETCH;
`endif
        default: state_q <= FETCH;
      endcase
    end
  end

  mc_control_decode u_decode (
    .state         (state_q),
    .opcode        (opcode),
    .mem_ready     (mem_ok),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: per-instruction cycle traces from an instruction-level model.
// Honours MC_CTRL_ADDI_EN for the addi expectations.
module tb_mc_control_fsm;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef struct packed {
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic illegal_op;
  } ctl_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op;
  logic [3:0] state;
  ctl_t       obs;

  int n_checks = 0;
  int n_fail   = 0;

  ctl_t exp_q[$];
  bit   rdy_q[$];

  mc_control_fsm #(.MEM_HANDSHAKE(1)) dut (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .mem_ready (mem_ready),
    .pc_write (pc_write), .pc_write_cond (pc_write_cond), .i_or_d (i_or_d),
    .mem_read (mem_read), .mem_write (mem_write), .ir_write (ir_write),
    .mem_to_reg (mem_to_reg), .reg_dst (reg_dst), .reg_write (reg_write),
    .alu_src_a (alu_src_a), .alu_src_b (alu_src_b), .alu_op (alu_op),
    .pc_source (pc_source), .illegal_op (illegal_op), .state (state)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_legal(input logic [5:0] op);
    return op == T_LW || op == T_SW || op == T_RTYPE || op == T_BEQ ||
           op == T_J || (ADDI_EN && op == T_ADDI);
  endfunction

  // Latency table in cycles with zero memory wait; illegal = FETCH + DECODE.
  function automatic int base_latency(input logic [5:0] op);
    if (op == T_LW) return 5;
    if (op == T_SW || op == T_RTYPE) return 4;
    if (ADDI_EN && op == T_ADDI) return 4;
    if (op == T_BEQ || op == T_J) return 3;
    return 2;
  endfunction

  task automatic push(input bit r, input ctl_t c);
    rdy_q.push_back(r);
    exp_q.push_back(c);
  endtask

  task automatic build(input logic [5:0] op, input int fw, input int mw);
    ctl_t c;
    exp_q.delete();
    rdy_q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
      c.ir_write = (i == fw); c.pc_write = (i == fw);
      push(i == fw, c);
    end
    c = '0; c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op);
    push(1'($urandom), c);
    if (op == T_LW || op == T_SW) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
      push(1'($urandom), c);
      for (int i = 0; i <= mw; i++) begin
        c = '0; c.i_or_d = 1;
        if (op == T_LW) c.mem_read = 1; else c.mem_write = 1;
        push(i == mw, c);
      end
      if (op == T_LW) begin
        c = '0; c.mem_to_reg = 1; c.reg_write = 1;
        push(1'($urandom), c);
      end
    end else if (op == T_RTYPE) begin
      c = '0; c.alu_src_a = 1; c.alu_op = 2'b10; push(1'($urandom), c);
      c = '0; c.reg_dst = 1; c.reg_write = 1;    push(1'($urandom), c);
    end else if (op == T_BEQ) begin
      c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01;
      push(1'($urandom), c);
    end else if (op == T_J) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'b10; push(1'($urandom), c);
    end else if (ADDI_EN && op == T_ADDI) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; push(1'($urandom), c);
      c = '0; c.reg_write = 1;                      push(1'($urandom), c);
    end
  endtask

  // Starts #1 after a rising edge with the DUT in FETCH; ends the same way.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
    int lat = 0;
    int exp_lat;
    bit left = 0;
    build(op, fw, mw);
    exp_lat = base_latency(op) + fw + ((op == T_LW || op == T_SW) ? mw : 0);
    opcode = op;
    for (int cyc = 0; cyc < 40 && lat == 0; cyc++) begin
      mem_ready = (cyc < rdy_q.size()) ? rdy_q[cyc] : 1'b1;
      @(negedge clk);
      if (cyc < exp_q.size()) begin
        n_checks++;
        if (obs !== exp_q[cyc]) begin
          n_fail++;
          $display("FAIL %s op=%b cyc %0d: outputs %h, expected %h", name, op, cyc, obs, exp_q[cyc]);
        end
      end
      @(posedge clk); #1;
      if (state !== 4'd0) left = 1;
      else if (left) lat = cyc + 1;
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency op=%b: %0d cycles, expected %0d", name, op, lat, exp_lat);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    ctl_t c;
    c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
    n_checks++;
    if (obs !== c || state !== 4'd0) begin
      n_fail++;
      $display("FAIL %s: outputs %h state %0d, expected %h state 0", name, obs, state, c);
    end
  endtask

  task automatic release_reset();
    mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b111111;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    release_reset();
  endtask

  task automatic test_rtype();
    run_instr("rtype", T_RTYPE, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", T_LW, 0, 2);
    run_instr("lw_fetch_wait", T_LW, 1, 0);
  endtask

  task automatic test_sw();
    run_instr("sw", T_SW, 0, 0);
  endtask

  task automatic test_branch_jump();
    run_instr("beq", T_BEQ, 0, 0);
    run_instr("j", T_J, 2, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 6'b111111, 0, 0);
  endtask

  task automatic test_addi();
    run_instr("addi", T_ADDI, 0, 0);
  endtask

  task automatic test_reset_in_memwr();
    opcode = T_SW; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL memwr_wait: mem_write %b, expected 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_memwr");
    mem_ready = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("reset_in_memwr_held");
    release_reset();
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] op;
    ops = '{T_LW, T_SW, T_RTYPE, T_BEQ, T_J, T_ADDI, 6'b000000};
    for (int i = 0; i < 150; i++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 6) == 0) op = 6'($urandom);
      run_instr("random", op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_addi();
    test_reset_in_memwr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
